// File: rtl/arb_pkg.sv
// Shared arbitration-mode encodings for the request arbiter slice.
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/rotating_prio_search.sv
// Combinational search for the first set bit of vec, scanning upward from
// start and wrapping from N-1 back to 0.
module rotating_prio_search #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  int unsigned cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // start is always < N, so a single subtraction completes the wrap
      cand = 32'(start) + k;
      if (cand >= N) cand = cand - N;
      if (vec[cand]) begin
        found = 1'b1;
        idx   = IW'(cand);
        break;
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with valid/ready hold; fixed-priority or
// round-robin selection chosen by MODE.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = ARB_FIXED,
  localparam int IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  out_onehot
);

  logic          valid_q, valid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  onehot_q, onehot_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          accept, load;
  logic [IW-1:0] idx_inc, start;
  logic          sel_found;
  logic [IW-1:0] sel_idx;

  assign accept  = valid_q & out_ready;
  assign load    = ~valid_q | accept;
  // Explicit wrap so non-power-of-two N never produces index N
  assign idx_inc = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    start = '0;
    if (MODE == ARB_RR) start = accept ? idx_inc : ptr_q;
  end

  rotating_prio_search #(.N(N)) u_search (
    .vec   (req),
    .start (start),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    if (load) begin
      valid_d  = sel_found;
      idx_d    = sel_found ? sel_idx : '0;
      onehot_d = sel_found ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;
    end
    if (MODE == ARB_RR && accept) ptr_d = idx_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed and randomized self-checking bench: fixed-priority N=8 and
// round-robin N=5 instances share clock and reset.
module tb_rr_priority_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] req_f;
  logic       rdy_f;
  logic       v_f;
  logic [2:0] idx_f;
  logic [7:0] oh_f;
  logic [4:0] req_r;
  logic       rdy_r;
  logic       v_r;
  logic [2:0] idx_r;
  logic [4:0] oh_r;

  int checks   = 0;
  int failures = 0;

  rr_priority_arbiter #(.N(8), .MODE(0)) u_fix (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_f),
    .out_valid  (v_f),
    .out_ready  (rdy_f),
    .out_idx    (idx_f),
    .out_onehot (oh_f)
  );

  rr_priority_arbiter #(.N(5), .MODE(1)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_r),
    .out_valid  (v_r),
    .out_ready  (rdy_r),
    .out_idx    (idx_r),
    .out_onehot (oh_r)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    req_f = '0;
    req_r = '0;
    #2;
    chk("rst_v_f",   64'(v_f),   64'd0);
    chk("rst_idx_f", 64'(idx_f), 64'd0);
    chk("rst_oh_f",  64'(oh_f),  64'd0);
    chk("rst_v_r",   64'(v_r),   64'd0);
    chk("rst_idx_r", 64'(idx_r), 64'd0);
    chk("rst_oh_r",  64'(oh_r),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] lowest8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stim
    logic [2:0] exp_seq [6];
    logic       pv;
    logic [2:0] pidx;
    logic [4:0] poh;
    logic       prdy;
    logic [4:0] lreq_r;
    logic [7:0] lreq_f;

    rst_n = 1'b1;
    req_f = '0; rdy_f = 1'b0;
    req_r = '0; rdy_r = 1'b0;
    #1;
    apply_reset();

    // Fixed priority: lowest set bit, 0 request clears outputs
    rdy_f = 1'b1;
    req_f = 8'hA0; step();
    chk("fix_a0_v",   64'(v_f),   64'd1);
    chk("fix_a0_idx", 64'(idx_f), 64'd5);
    chk("fix_a0_oh",  64'(oh_f),  64'h20);
    req_f = 8'h00; step();
    chk("fix_zero_v",   64'(v_f),   64'd0);
    chk("fix_zero_idx", 64'(idx_f), 64'd0);
    chk("fix_zero_oh",  64'(oh_f),  64'd0);
    req_f = 8'h80; step();
    chk("fix_80_idx", 64'(idx_f), 64'd7);
    req_f = 8'h81; step();
    chk("fix_81_idx", 64'(idx_f), 64'd0);
    step();
    chk("fix_81_again", 64'(idx_f), 64'd0);

    // Round robin, all requesting: 0,1,2,3,4,0
    apply_reset();
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    rdy_r = 1'b1;
    req_r = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rr_all_%0d", i), 64'(idx_r), 64'(exp_seq[i]));
    end
    chk("rr_all_v", 64'(v_r), 64'd1);

    // Wrap 4 -> 0 with sparse requests
    apply_reset();
    exp_seq = '{3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 3'd4};
    rdy_r = 1'b1;
    req_r = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_wrap_%0d", i), 64'(idx_r), 64'(exp_seq[i]));
    end

    // Hold under back-pressure despite the granted bit dropping
    apply_reset();
    rdy_r = 1'b1;
    req_r = 5'b00100; step();
    chk("hold_first", 64'(idx_r), 64'd2);
    rdy_r = 1'b0;
    req_r = 5'b00010; step();
    chk("hold_idx", 64'(idx_r), 64'd2);
    chk("hold_v",   64'(v_r),   64'd1);
    chk("hold_oh",  64'(oh_r),  64'b00100);
    step();
    chk("hold_idx2", 64'(idx_r), 64'd2);
    rdy_r = 1'b1; step();
    chk("hold_next", 64'(idx_r), 64'd1);

    // Asynchronous reset during a hold
    apply_reset();
    rdy_r = 1'b1;
    req_r = 5'b01000; step();
    chk("ar_grant", 64'(idx_r), 64'd3);
    rdy_r = 1'b0; step();
    chk("ar_held", 64'(idx_r), 64'd3);
    rst_n = 1'b0;
    #2;
    chk("ar_v",   64'(v_r),   64'd0);
    chk("ar_idx", 64'(idx_r), 64'd0);
    chk("ar_oh",  64'(oh_r),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_r = 5'b11000;
    rdy_r = 1'b1;
    step();
    chk("ar_after_v",   64'(v_r),   64'd1);
    chk("ar_after_idx", 64'(idx_r), 64'd3);

    // Randomized property checks
    apply_reset();
    lreq_r = '0;
    lreq_f = '0;
    for (int n = 0; n < 10000; n++) begin
      req_r = 5'($urandom);
      rdy_r = ($urandom_range(0, 3) != 0);
      req_f = 8'($urandom) & 8'($urandom);
      rdy_f = 1'($urandom);
      pv    = v_r;
      pidx  = idx_r;
      poh   = oh_r;
      prdy  = rdy_r;
      if (!v_r || rdy_r) lreq_r = req_r;
      if (!v_f || rdy_f) lreq_f = req_f;
      step();
      if (pv && !prdy)
        chk("rnd_hold", {v_r, idx_r, oh_r}, {1'b1, pidx, poh});
      chk("rnd_v", 64'(v_r), 64'(|lreq_r));
      if (v_r) chk("rnd_req_set", 64'(lreq_r[idx_r]), 64'd1);
      chk("rnd_oh", 64'(oh_r), v_r ? (64'd1 << idx_r) : 64'd0);
      chk("rnd_fix_v",   64'(v_f),   64'(|lreq_f));
      chk("rnd_fix_idx", 64'(idx_f), 64'(lowest8(lreq_f)));
      chk("rnd_fix_oh",  64'(oh_f),  v_f ? (64'd1 << idx_f) : 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
